// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the programmable divide-by-N enable generator.
// Imported by clk_div_phase and clk_div_n_pulse.
package clk_div_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int OUT_W_DEF       = 2;
  localparam int DEFAULT_DIV_DEF = 4;

  // A divisor of zero has no meaningful period, so it is treated as divide-by-1.
  function automatic int unsigned min1(input int unsigned div);
    return (div == 0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Phase counter, terminal-count (wrap) detection and divisor shadow register.
// A new divisor only takes effect at a period boundary, so the phase never glitches.
module clk_div_phase
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div_val,
  output logic [DIV_W-1:0] o_cnt,
  output logic [DIV_W-1:0] o_div_act,
  output logic             o_wrap
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_pend_val;
  logic             r_pend;
  logic             w_wrap;
  logic             w_apply;

  // A clear overrides both enable and wrap, but still counts as a boundary for applying a pending divisor.
  assign w_wrap  = i_en && !i_clr && (r_cnt == (r_div_act - DIV_W'(1)));
  assign w_apply = (w_wrap || i_clr) && r_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_div_act  <= DIV_W'(DEFAULT_DIV);
      r_pend_val <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (i_clr || w_wrap) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end

      if (w_apply) begin
        r_div_act <= r_pend_val;
        r_pend    <= 1'b0;
      end

      // Only a pend flag set in an earlier cycle is applied; a load on the wrap cycle waits a full period.
      if (i_div_load) begin
        r_pend_val <= DIV_W'(min1(32'(i_div_val)));
        r_pend     <= 1'b1;
      end
    end
  end

  assign o_cnt     = r_cnt;
  assign o_div_act = r_div_act;
  assign o_wrap    = w_wrap;

endmodule

// File: rtl/clk_div_n_pulse.sv
// Runtime-programmable divide-by-N enable generator: pulse, square wave and pulse counter.
// Optional macro CLK_DIV_SYNC_CLR_EN adds a sync_clr input that realigns the phase of several dividers.
module clk_div_n_pulse
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_DIV_SYNC_CLR_EN
  input  logic             sync_clr,
`endif
  output logic             div_pulse,
  output logic             clk_out,
  output logic [OUT_W-1:0] po_cnt,
  output logic [DIV_W-1:0] div_act
);

  logic             w_clr;
  logic             w_wrap;
  logic [DIV_W-1:0] w_cnt;
  logic [DIV_W-1:0] w_div_act;
  logic             r_div_pulse;
  logic             r_clk_out;
  logic [OUT_W-1:0] r_po_cnt;

`ifdef CLK_DIV_SYNC_CLR_EN
  assign w_clr = sync_clr;
`else
  assign w_clr = 1'b0;
`endif

  clk_div_phase #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_phase (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_clr      (w_clr),
    .i_div_load (div_load),
    .i_div_val  (div_val),
    .o_cnt      (w_cnt),
    .o_div_act  (w_div_act),
    .o_wrap     (w_wrap)
  );

  // High for the first floor(N/2) phases of each period; N=1 therefore stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_pulse <= 1'b0;
      r_clk_out   <= 1'b0;
      r_po_cnt    <= '0;
    end else begin
      r_div_pulse <= w_wrap;
      if (w_clr) begin
        r_clk_out <= 1'b0;
      end else if (en) begin
        r_clk_out <= (w_cnt < (w_div_act >> 1));
      end
      if (r_div_pulse) begin
        r_po_cnt <= r_po_cnt + OUT_W'(1);
      end
    end
  end

  assign div_pulse = r_div_pulse;
  assign clk_out   = r_clk_out;
  assign po_cnt    = r_po_cnt;
  assign div_act   = w_div_act;

endmodule

// File: tb/tb_clk_div_n_pulse.sv
// Self-checking bench for clk_div_n_pulse: period-level model plus directed scenarios.
// Build with CLK_DIV_SYNC_CLR_EN defined to also exercise sync_clr.
module tb_clk_div_n_pulse;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       sync_clr;
  logic       div_pulse;
  logic       clk_out;
  logic [1:0] po_cnt;
  logic [7:0] div_act;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  clk_div_n_pulse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
`ifdef CLK_DIV_SYNC_CLR_EN
    .sync_clr  (sync_clr),
`endif
    .div_pulse (div_pulse),
    .clk_out   (clk_out),
    .po_cnt    (po_cnt),
    .div_act   (div_act)
  );

  // ---------------- behavioural model ----------------
  // Phase is an integer position within the current period; outputs follow the period rules.
  int   m_phase;
  int   m_n;
  int   m_pend_n;
  bit   m_pend;
  bit   m_pulse;
  bit   m_clk;
  int   m_pulse_total;
  logic m_sclr;
  logic m_wrap;

  always_comb begin
    m_sclr = 1'b0;
`ifdef CLK_DIV_SYNC_CLR_EN
    m_sclr = sync_clr;
`endif
    m_wrap = en && !m_sclr && (m_phase == m_n - 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase       <= 0;
      m_n           <= 4;
      m_pend        <= 0;
      m_pend_n      <= 0;
      m_pulse       <= 0;
      m_clk         <= 0;
      m_pulse_total <= 0;
    end else begin
      m_phase <= (m_sclr || m_wrap) ? 0 : (en ? m_phase + 1 : m_phase);
      if ((m_sclr || m_wrap) && m_pend) begin
        m_n    <= m_pend_n;
        m_pend <= 0;
      end
      if (div_load) begin
        m_pend   <= 1;
        m_pend_n <= (div_val == 8'd0) ? 1 : int'(div_val);
      end
      m_pulse       <= m_wrap;
      m_clk         <= m_sclr ? 1'b0 : (en ? (m_phase < m_n / 2) : m_clk);
      m_pulse_total <= m_pulse_total + (m_pulse ? 1 : 0);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cmp_div_pulse", 32'(div_pulse), 32'(m_pulse));
      check("cmp_clk_out",   32'(clk_out),   32'(m_clk));
      check("cmp_po_cnt",    32'(po_cnt),    32'(m_pulse_total % 4));
      check("cmp_div_act",   32'(div_act),   32'(m_n));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pulse(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (div_pulse !== 1'b1 && n < 64);
    if (div_pulse !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no div_pulse within %0d cycles", name, n);
    end
  endtask

  task automatic load_div(input logic [7:0] val);
    div_val  = val;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] pul_v;
  logic [31:0] clk_v;
  logic [1:0]  po_s[21];
  int          n;
  logic [1:0]  po_saved;

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_val  = 8'd0;
    div_load = 1'b0;
    sync_clr = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_div_pulse", 32'(div_pulse), 0);
    check("rst_clk_out",   32'(clk_out),   0);
    check("rst_po_cnt",    32'(po_cnt),    0);
    check("rst_div_act",   32'(div_act),   4);

    // Default N=4 from reset release.
    rst_n = 1'b1;
    en    = 1'b1;
    pul_v = '0;
    clk_v = '0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      pul_v[i] = div_pulse;
      clk_v[i] = clk_out;
      po_s[i]  = po_cnt;
    end
    check("n4_pulse_pattern", pul_v, 32'h0008_8888);
    check("n4_clk_pattern",   clk_v, 32'h0013_3333);
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 1; k <= 5; k++) begin
      check("n4_po_seq", 32'(po_s[4*k]), 32'(exp_q.pop_front()));
    end

    // Load N=5 mid-period: current 4-cycle period completes first.
    load_div(8'd5);
    check("n5_act_before_wrap", 32'(div_act), 4);
    wait_pulse("n5_first", n);
    check("n5_first_gap", n, 2);
    check("n5_act_after_wrap", 32'(div_act), 5);
    wait_pulse("n5_second", n);
    check("n5_period_a", n, 5);
    wait_pulse("n5_third", n);
    check("n5_period_b", n, 5);
    clk_v = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clk_v[i] = clk_out;
    end
    check("n5_clk_pattern", clk_v, 32'h0000_0003);
    check("n5_pulse_end", 32'(div_pulse), 1);

    // Divisor 0 clamps to 1.
    load_div(8'd0);
    wait_pulse("n1_switch", n);
    check("n1_switch_gap", n, 4);
    check("n1_div_act", 32'(div_act), 1);
    pul_v = '0;
    clk_v = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pul_v[i] = div_pulse;
      clk_v[i] = clk_out;
    end
    check("n1_pulse_every_cycle", pul_v, 32'h0000_000f);
    check("n1_clk_low", clk_v, 32'h0000_0000);

    // Load coincident with a wrap is applied one wrap later.
    load_div(8'd4);
    check("coinc_act_hold", 32'(div_act), 1);
    check("coinc_pulse_a", 32'(div_pulse), 1);
    @(negedge clk);
    check("coinc_act_apply", 32'(div_act), 4);
    check("coinc_pulse_b", 32'(div_pulse), 1);

    // Enable low for 3 cycles at phase 2.
    repeat (2) @(negedge clk);
    en    = 1'b0;
    pul_v = '0;
    clk_v = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pul_v[i] = div_pulse;
      clk_v[i] = clk_out;
    end
    check("en_low_no_pulse", pul_v, 32'h0000_0000);
    check("en_low_clk_frozen", clk_v, 32'h0000_0007);
    en = 1'b1;
    wait_pulse("en_resume", n);
    check("en_resume_gap", n, 2);

    // Asynchronous reset with a load pending.
    load_div(8'd7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_div_pulse", 32'(div_pulse), 0);
    check("arst_clk_out",   32'(clk_out),   0);
    check("arst_po_cnt",    32'(po_cnt),    0);
    check("arst_div_act",   32'(div_act),   4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse("arst_first", n);
    check("arst_first_gap", n, 4);
    wait_pulse("arst_second", n);
    check("arst_pend_discarded", n, 4);
    check("arst_div_act_kept", 32'(div_act), 4);

`ifdef CLK_DIV_SYNC_CLR_EN
    // sync_clr at phase 3 suppresses the pulse and restarts the period.
    repeat (3) @(negedge clk);
    po_saved = po_cnt;
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    check("sclr_no_pulse", 32'(div_pulse), 0);
    check("sclr_clk_low",  32'(clk_out),   0);
    check("sclr_po_kept",  32'(po_cnt),    32'(po_saved));
    wait_pulse("sclr_restart", n);
    check("sclr_restart_gap", n, 4);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
